// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa -- RC4 key-scheduling stage.
//
// Permutes a 256-byte S memory in place with a 3-byte key, following the
// standard RC4 key schedule:
//   for i = 0..255: j = j + s[i] + key[i mod 3]; swap s[i], s[j]
// The memory is single-port with a 1-cycle read latency, so every iteration
// is a fixed six-cycle sequence: read s[i], wait, read s[j], wait,
// write s[i], write s[j].
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous active-high reset
//   en      in   1  start request, honoured only while rdy=1
//   rdy     out  1  idle and able to accept en
//   key     in  24  RC4 key, byte 0 = key[23:16], byte 2 = key[7:0]
//   addr    out  8  S memory address
//   rddata  in   8  S memory read data (valid one cycle after addr)
//   wrdata  out  8  S memory write data
//   wren    out  1  S memory write enable
//
// All outputs are registered; rddata and en only reach outputs through
// flops.
// ---------------------------------------------------------------------------
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        WT_I = 3'd2,
        RD_J = 3'd3,
        WT_J = 3'd4,
        WR_I = 3'd5,
        WR_J = 3'd6
    } state_t;

    state_t      state_r;
    logic [7:0]  i_r;
    logic [7:0]  j_r;
    logic [1:0]  kidx_r;     // tracks i mod 3 without a divider
    logic [7:0]  si_r;
    logic [23:0] key_r;

    logic [7:0]  key_byte_s;
    logic [7:0]  j_next_s;

    // Step the mod-3 key index: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] kidx_advance(input logic [1:0] k);
        if (k == 2'd2) begin
            return 2'd0;
        end else begin
            return k + 2'd1;
        end
    endfunction

    // Select the key byte for the current iteration.
    always_comb begin
        key_byte_s = 8'd0;
        case (kidx_r)
            2'd0:    key_byte_s = key_r[23:16];
            2'd1:    key_byte_s = key_r[15:8];
            2'd2:    key_byte_s = key_r[7:0];
            default: key_byte_s = 8'd0;
        endcase
    end

    // New j from s[i] as it arrives on rddata; 8-bit add wraps mod 256.
    always_comb begin
        j_next_s = 8'd0;
        j_next_s = j_r + rddata + key_byte_s;
    end

    // Key-schedule FSM. Outputs are loaded on the transition into a state so
    // that they hold that state's bus values for its whole cycle. The wrdata
    // register loaded in WT_J doubles as the s[j] holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            i_r     <= 8'd0;
            j_r     <= 8'd0;
            kidx_r  <= 2'd0;
            si_r    <= 8'd0;
            key_r   <= 24'd0;
            rdy     <= 1'b1;
            addr    <= 8'd0;
            wrdata  <= 8'd0;
            wren    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en) begin
                        key_r   <= key;
                        i_r     <= 8'd0;
                        j_r     <= 8'd0;
                        kidx_r  <= 2'd0;
                        rdy     <= 1'b0;
                        addr    <= 8'd0;
                        wrdata  <= 8'd0;
                        wren    <= 1'b0;
                        state_r <= RD_I;
                    end else begin
                        rdy     <= 1'b1;
                        addr    <= 8'd0;
                        wrdata  <= 8'd0;
                        wren    <= 1'b0;
                        state_r <= IDLE;
                    end
                end

                RD_I: begin
                    addr    <= i_r;
                    wren    <= 1'b0;
                    state_r <= WT_I;
                end

                WT_I: begin
                    si_r    <= rddata;
                    j_r     <= j_next_s;
                    addr    <= j_next_s;
                    wren    <= 1'b0;
                    state_r <= RD_J;
                end

                RD_J: begin
                    addr    <= j_r;
                    wren    <= 1'b0;
                    state_r <= WT_J;
                end

                WT_J: begin
                    // rddata is s[j]; it goes straight out as the s[i] write.
                    addr    <= i_r;
                    wrdata  <= rddata;
                    wren    <= 1'b1;
                    state_r <= WR_I;
                end

                WR_I: begin
                    addr    <= j_r;
                    wrdata  <= si_r;
                    wren    <= 1'b1;
                    state_r <= WR_J;
                end

                WR_J: begin
                    wrdata <= 8'd0;
                    wren   <= 1'b0;
                    if (i_r == 8'd255) begin
                        // i stays at 255 on the last iteration.
                        rdy     <= 1'b1;
                        addr    <= 8'd0;
                        state_r <= IDLE;
                    end else begin
                        i_r     <= i_r + 8'd1;
                        kidx_r  <= kidx_advance(kidx_r);
                        addr    <= i_r + 8'd1;
                        state_r <= RD_I;
                    end
                end

                default: begin
                    rdy     <= 1'b1;
                    addr    <= 8'd0;
                    wrdata  <= 8'd0;
                    wren    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ksa.md
# ksa

Key-scheduling stage of the RC4 datapath. Sits directly downstream of `init`. Once `init` has filled the 256-byte S memory with s[i] = i, this block permutes S in place using a 24-bit key, following the standard RC4 KSA:

- for i = 0..255: j = (j + s[i] + key[i mod 3]) mod 256; swap s[i], s[j].

It shares the same single-port synchronous S memory and the same en/rdy handshake as `init`. A top-level arbiter muxes the memory port between the two blocks.

## Interface

Parameters:
- None. Key length is fixed at 3 bytes; memory depth is fixed at 256.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  start request; honoured only in a cycle where `rdy`=1.
- `rdy`  out  1  high when idle and able to accept `en`.
- `key`  in  24  RC4 key, latched on accepted `en`. Byte 0 = `key[23:16]`, byte 1 = `key[15:8]`, byte 2 = `key[7:0]`.
- `addr`  out  8  S memory address.
- `rddata`  in  8  S memory read data, valid one cycle after `addr` is presented.
- `wrdata`  out  8  S memory write data.
- `wren`  out  1  S memory write enable.

## Operation

Internal registers:
- `i` (8 bits), `j` (8 bits).
- `kidx`: a mod-3 counter. It replaces i mod 3; no divider is used.
- `si`, `sj` (8 bits each).
- latched key (24 bits).

States: IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J.

- **IDLE:** `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0.
  - On `en`=1: latch `key`; set i=0, j=0, kidx=0; go to RD_I.
- **RD_I:** `addr`=i, `wren`=0. Go to WT_I.
- **WT_I:** `addr`=i, `wren`=0. `rddata` holds s[i].
  - si ← rddata.
  - j ← j + rddata + keybyte[kidx], mod 256 (8-bit wrap, carries discarded).
  - Go to RD_J.
- **RD_J:** `addr`=j (the updated value), `wren`=0. Go to WT_J.
- **WT_J:** `addr`=j, `wren`=0. sj ← rddata. Go to WR_I.
- **WR_I:** `addr`=i, `wrdata`=sj, `wren`=1. Go to WR_J.
- **WR_J:** `addr`=j, `wrdata`=si, `wren`=1.
  - If i==255: go to IDLE.
  - Otherwise: i ← i+1; kidx ← (kidx==2) ? 0 : kidx+1; go to RD_I.

Boundary conditions:
- **i==j:** both writes carry the same value (si==sj). S is unchanged. Both write cycles still occur.
- **`en` while busy:** ignored. `key` changes while busy are ignored.
- **`rst`** (any state, including mid-permutation): next cycle is IDLE with `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0, i=j=0, kidx=0. S contents are left partially permuted; the block does not restore them.
- **Final iteration:** i stays 255 and does not wrap to 0.

## Timing

- Reset values: `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0.
- `en` sampled in cycle T with `rdy`=1: `rdy`=0 from cycle T+1, the first RD_I cycle.
- Each iteration takes exactly 6 cycles. The full permutation takes 256×6 = 1536 cycles.
- `rdy` returns to 1 in cycle T+1537. At most one WR_J write is in flight at that boundary; the block is in IDLE with `wren`=0.
- Back-to-back start: `en` held high through completion restarts on the first IDLE cycle. `rdy` is high for exactly one cycle in that case.
- No combinational path from `rddata` or `en` to any output.
- Memory model: single-port; write takes effect at the clock edge ending a `wren`=1 cycle; read is registered-address, 1-cycle latency.

## Test plan

- **Reset/idle:** assert `rst` for 2 cycles → `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0. `en`=0 for 10 cycles → outputs unchanged.
- **Handshake/latency:** memory preloaded with s[i]=i, key=24'h000000, pulse `en` → `rdy`=0 next cycle.
  - First iteration bus trace: `addr` 0,0,0,0,0,0 with `wren`=0,0,0,0,1,1 and `wrdata`=0 (i==j==0 self-swap).
  - `rdy`=1 exactly 1537 cycles after the `en` cycle.
- **Arithmetic:** same setup.
  - After i=2 writes, s[2]=3 and s[3]=2 (i=1: j=1; i=2: j=3).
  - The final 256-entry S matches a software RC4 KSA golden model, and the result is a permutation of 0..255.
- **Key indexing/wrap:** identity S, key=24'h00033C → final S equals the golden model. This exercises key bytes 0x00, 0x03, 0x3C cycling, and j mod-256 overflow.
- **Reset mid-operation:** assert `rst` for one cycle at iteration i=128 → `rdy`=1, `wren`=0, `addr`=0 on the next cycle.
  - A new `en` with a fresh identity S then completes in 1536 cycles with golden-correct output.
- **Busy `en` ignored:** pulse `en` and change `key` at iteration i=50 → completion time and final S are unchanged from an undisturbed run.
